// File: rtl/axi4_arw_arbiter.sv
// Arbitrates NUM_CH AW/AR channel pairs onto one registered combined address channel.
// Define ARW_WR_PRIO_EN for write-priority arbitration with reads forced in after MAX_RD_WAIT writes.
module axi4_arw_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int AID_LEN     = 4,
    parameter int AADDR_LEN   = 32,
    parameter int MAX_RD_WAIT = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        aclk_i,
    input  logic                        arst_i,
    input  logic [NUM_CH*AID_LEN-1:0]   awid_i,
    input  logic [NUM_CH*AADDR_LEN-1:0] awaddr_i,
    input  logic [NUM_CH*8-1:0]         awlen_i,
    input  logic [NUM_CH-1:0]           awvalid_i,
    output logic [NUM_CH-1:0]           awready_o,
    input  logic [NUM_CH*AID_LEN-1:0]   arid_i,
    input  logic [NUM_CH*AADDR_LEN-1:0] araddr_i,
    input  logic [NUM_CH*8-1:0]         arlen_i,
    input  logic [NUM_CH-1:0]           arvalid_i,
    output logic [NUM_CH-1:0]           arready_o,
    output logic [AID_LEN-1:0]          aid_o,
    output logic [AADDR_LEN-1:0]        aaddr_o,
    output logic [7:0]                  alen_o,
    output logic                        atype_o,
    output logic [CH_W-1:0]             asrc_o,
    output logic                        avalid_o,
    input  logic                        aready_i
);
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
    state_t state_reg, state_next;

    logic            load;
    logic            any_req;
    logic            grant;
    logic [CH_W-1:0] win_ch;
    logic            win_wr;

    logic [AID_LEN-1:0]   aw_id_arr   [NUM_CH];
    logic [AADDR_LEN-1:0] aw_addr_arr [NUM_CH];
    logic [7:0]           aw_len_arr  [NUM_CH];
    logic [AID_LEN-1:0]   ar_id_arr   [NUM_CH];
    logic [AADDR_LEN-1:0] ar_addr_arr [NUM_CH];
    logic [7:0]           ar_len_arr  [NUM_CH];

    logic [AID_LEN-1:0]   aid_reg;
    logic [AADDR_LEN-1:0] aaddr_reg;
    logic [7:0]           alen_reg;
    logic                 atype_reg;
    logic [CH_W-1:0]      asrc_reg;

    assign load  = !avalid_o || aready_i;
    // Readies are suppressed while reset is held so nothing is consumed that the slice drops.
    assign grant = load && any_req && !arst_i;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        assign aw_id_arr[gi]   = awid_i[gi*AID_LEN +: AID_LEN];
        assign aw_addr_arr[gi] = awaddr_i[gi*AADDR_LEN +: AADDR_LEN];
        assign aw_len_arr[gi]  = awlen_i[gi*8 +: 8];
        assign ar_id_arr[gi]   = arid_i[gi*AID_LEN +: AID_LEN];
        assign ar_addr_arr[gi] = araddr_i[gi*AADDR_LEN +: AADDR_LEN];
        assign ar_len_arr[gi]  = arlen_i[gi*8 +: 8];
        assign awready_o[gi]   = grant &&  win_wr && (win_ch == CH_W'(gi));
        assign arready_o[gi]   = grant && !win_wr && (win_ch == CH_W'(gi));
    end

`ifdef ARW_WR_PRIO_EN
    localparam int RW_W = $clog2(MAX_RD_WAIT + 1);

    logic [CH_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [RW_W-1:0] rd_wait_reg, rd_wait_next;
    logic [CH_W:0]   aw_pick, ar_pick;
    logic            any_aw, any_ar, pick_rd;

    // Returns {found, index} of the first set bit of v searching upward from ptr, wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] v, input logic [CH_W-1:0] ptr);
        logic [NUM_CH-1:0] rot;
        logic [CH_W:0]     sum;
        logic              found;
        logic [CH_W-1:0]   off;
        rot   = NUM_CH'({v, v} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = CH_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
        return {found, sum[CH_W-1:0]};
    endfunction

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    assign aw_pick = rr_pick(awvalid_i, wr_ptr_reg);
    assign ar_pick = rr_pick(arvalid_i, rd_ptr_reg);
    assign any_aw  = aw_pick[CH_W];
    assign any_ar  = ar_pick[CH_W];
    assign pick_rd = any_ar && (!any_aw || rd_wait_reg == RW_W'(MAX_RD_WAIT));
    assign any_req = any_aw || any_ar;
    assign win_wr  = !pick_rd;
    assign win_ch  = pick_rd ? ar_pick[CH_W-1:0] : aw_pick[CH_W-1:0];

    always_comb begin
        rd_wait_next = rd_wait_reg;
        if (!any_ar || (grant && !win_wr)) rd_wait_next = '0;
        else if (grant)                    rd_wait_next = rd_wait_reg + 1'b1;
    end

    always_ff @(posedge aclk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rd_wait_reg <= '0;
        end else begin
            rd_wait_reg <= rd_wait_next;
            if (grant && win_wr)  wr_ptr_reg <= ch_inc(win_ch);
            if (grant && !win_wr) rd_ptr_reg <= ch_inc(win_ch);
        end
    end
`else
    localparam int            NREQ   = 2 * NUM_CH;
    localparam int            RR_W   = $clog2(NREQ);
    localparam logic [RR_W:0] NREQ_V = (RR_W+1)'(NREQ);

    logic [NREQ-1:0] req_vec, req_rot;
    logic [RR_W-1:0] rr_ptr_reg, win_idx;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req
        assign req_vec[2*gi]   = awvalid_i[gi];
        assign req_vec[2*gi+1] = arvalid_i[gi];
    end

    // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
    assign req_rot = NREQ'({req_vec, req_vec} >> rr_ptr_reg);

    always_comb begin
        logic [RR_W-1:0] off;
        logic [RR_W:0]   sum;
        any_req = 1'b0;
        off     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_req && req_rot[i]) begin
                any_req = 1'b1;
                off     = RR_W'(i);
            end
        end
        sum = {1'b0, rr_ptr_reg} + {1'b0, off};
        if (sum >= NREQ_V) sum = sum - NREQ_V;
        win_idx = sum[RR_W-1:0];
    end

    assign win_wr = !win_idx[0];
    assign win_ch = CH_W'(win_idx >> 1);

    always_ff @(posedge aclk_i or posedge arst_i) begin
        if (arst_i)     rr_ptr_reg <= '0;
        else if (grant) rr_ptr_reg <= (win_idx == RR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
`endif

    always_ff @(posedge aclk_i or posedge arst_i) begin
        if (arst_i) state_reg <= ST_EMPTY;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (load) state_next = any_req ? ST_FULL : ST_EMPTY;
    end

    always_comb begin
        avalid_o = (state_reg == ST_FULL);
    end

    always_ff @(posedge aclk_i or posedge arst_i) begin
        if (arst_i) begin
            aid_reg   <= '0;
            aaddr_reg <= '0;
            alen_reg  <= '0;
            atype_reg <= 1'b0;
            asrc_reg  <= '0;
        end else if (grant) begin
            aid_reg   <= win_wr ? aw_id_arr[win_ch]   : ar_id_arr[win_ch];
            aaddr_reg <= win_wr ? aw_addr_arr[win_ch] : ar_addr_arr[win_ch];
            alen_reg  <= win_wr ? aw_len_arr[win_ch]  : ar_len_arr[win_ch];
            atype_reg <= win_wr;
            asrc_reg  <= win_ch;
        end
    end

    assign aid_o   = aid_reg;
    assign aaddr_o = aaddr_reg;
    assign alen_o  = alen_reg;
    assign atype_o = atype_reg;
    assign asrc_o  = asrc_reg;
endmodule

// File: tb/tb_axi4_arw_arbiter.sv
// Bench for axi4_arw_arbiter: vector table, corner sequences and a random run against a queue-free reference model.
`timescale 1ns/1ps
module tb_axi4_arw_arbiter;
    localparam int NUM_CH = 2, AID_LEN = 4, AADDR_LEN = 32, MAX_RD_WAIT = 4, CH_W = 1;

    logic                        clk = 1'b0, arst = 1'b1;
    logic [NUM_CH*AID_LEN-1:0]   awid, arid;
    logic [NUM_CH*AADDR_LEN-1:0] awaddr, araddr;
    logic [NUM_CH*8-1:0]         awlen, arlen;
    logic [NUM_CH-1:0]           awvalid, arvalid, awready, arready;
    logic [AID_LEN-1:0]          aid;
    logic [AADDR_LEN-1:0]        aaddr;
    logic [7:0]                  alen;
    logic                        atype, avalid, aready;
    logic [CH_W-1:0]             asrc;

    axi4_arw_arbiter #(.NUM_CH(NUM_CH), .AID_LEN(AID_LEN), .AADDR_LEN(AADDR_LEN), .MAX_RD_WAIT(MAX_RD_WAIT)) dut (
        .aclk_i(clk), .arst_i(arst),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready),
        .aid_o(aid), .aaddr_o(aaddr), .alen_o(alen), .atype_o(atype), .asrc_o(asrc),
        .avalid_o(avalid), .aready_i(aready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: the pending combined request plus arbitration bookkeeping as plain integers.
    bit                   m_valid;
    int                   m_rr, m_wr, m_rd, m_wait;
    logic [AID_LEN-1:0]   m_id;
    logic [AADDR_LEN-1:0] m_addr;
    logic [7:0]           m_len;
    logic                 m_type;
    logic [CH_W-1:0]      m_src;
    logic [NUM_CH-1:0]    s_aw, s_ar;

    typedef struct {
        logic [1:0] awv, arv;
        logic       rdy;
        logic [1:0] e_aw, e_ar;
        logic       e_valid, e_src, e_type;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rr = 0; m_wr = 0; m_rd = 0; m_wait = 0;
        m_id = '0; m_addr = '0; m_len = '0; m_type = 0; m_src = '0;
    endtask

    // Requester index of the winner (2k = AW k, 2k+1 = AR k), or -1 when nothing is valid.
    function automatic int model_pick();
`ifdef ARW_WR_PRIO_EN
        if (|arvalid && (!(|awvalid) || m_wait == MAX_RD_WAIT)) begin
            for (int i = 0; i < NUM_CH; i++)
                if (arvalid[(m_rd + i) % NUM_CH]) return 2 * ((m_rd + i) % NUM_CH) + 1;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (awvalid[(m_wr + i) % NUM_CH]) return 2 * ((m_wr + i) % NUM_CH);
        return -1;
`else
        for (int i = 0; i < 2 * NUM_CH; i++) begin
            int j = (m_rr + i) % (2 * NUM_CH);
            if ((j % 2 == 0) ? awvalid[j / 2] : arvalid[j / 2]) return j;
        end
        return -1;
`endif
    endfunction

    task automatic model_update(input int g, input bit ld);
        int k;
        bit wr;
        k  = (g < 0) ? 0 : g / 2;
        wr = (g % 2 == 0);
`ifdef ARW_WR_PRIO_EN
        if (!(|arvalid))           m_wait = 0;
        else if (ld && g >= 0)     m_wait = wr ? m_wait + 1 : 0;
`endif
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1;
                m_type  = wr;
                m_src   = CH_W'(k);
                m_id    = wr ? awid[k*AID_LEN +: AID_LEN]       : arid[k*AID_LEN +: AID_LEN];
                m_addr  = wr ? awaddr[k*AADDR_LEN +: AADDR_LEN] : araddr[k*AADDR_LEN +: AADDR_LEN];
                m_len   = wr ? awlen[k*8 +: 8]                  : arlen[k*8 +: 8];
                m_rr    = (g + 1) % (2 * NUM_CH);
                if (wr) m_wr = (k + 1) % NUM_CH;
                else    m_rd = (k + 1) % NUM_CH;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: readies checked mid-cycle, registered outputs checked just after the edge.
    task automatic tick();
        int g;
        bit ld;
        logic [NUM_CH-1:0] e_aw, e_ar;
        @(negedge clk);
        g  = model_pick();
        ld = !m_valid || aready;
        e_aw = '0; e_ar = '0;
        if (ld && g >= 0) begin
            if (g % 2 == 0) e_aw[g / 2] = 1'b1;
            else            e_ar[g / 2] = 1'b1;
        end
        s_aw = awready; s_ar = arready;
        chk("awready", awready, e_aw);
        chk("arready", arready, e_ar);
        @(posedge clk);
        model_update(g, ld);
        #1;
        chk("avalid", avalid, m_valid);
        if (m_valid) begin
            chk("aid", aid, m_id);
            chk("aaddr", aaddr, m_addr);
            chk("alen", alen, m_len);
            chk("atype", atype, m_type);
            chk("asrc", asrc, m_src);
        end
    endtask

    task automatic drive(input logic [NUM_CH-1:0] awv, input logic [NUM_CH-1:0] arv, input logic rdy);
        awvalid = awv; arvalid = arv; aready = rdy;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avalid", avalid, 0);
        chk("rst_aid", aid, 0);
        chk("rst_aaddr", aaddr, 0);
        chk("rst_alen", alen, 0);
        chk("rst_atype", atype, 0);
        chk("rst_asrc", asrc, 0);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        arst = 1'b0;
    endtask

    task automatic fixed_payload();
        for (int k = 0; k < NUM_CH; k++) begin
            awid[k*AID_LEN +: AID_LEN]       = AID_LEN'(k + 1);
            arid[k*AID_LEN +: AID_LEN]       = AID_LEN'(k + 9);
            awaddr[k*AADDR_LEN +: AADDR_LEN] = 32'h1000 + 32'(k * 16'h100);
            araddr[k*AADDR_LEN +: AADDR_LEN] = 32'h8000 + 32'(k * 16'h100);
            awlen[k*8 +: 8]                  = 8'(k + 3);
            arlen[k*8 +: 8]                  = 8'(k + 7);
        end
    endtask

    initial begin
        fixed_payload();
        drive('1, '1, 1'b1);
        model_reset();
        do_reset();

        // Single AW0 request
        arst = 1'b1;
        drive('0, '0, 1'b1);
        do_reset();
        awid[0 +: AID_LEN] = 4'd3; awaddr[0 +: AADDR_LEN] = 32'h100; awlen[0 +: 8] = 8'd15;
        drive(2'b01, 2'b00, 1'b1);
        tick();
        chk("single_awready", s_aw, 2'b01);
        chk("single_aaddr", aaddr, 32'h100);
        chk("single_alen", alen, 15);
        chk("single_aid", aid, 3);
        chk("single_atype", atype, 1);
        chk("single_asrc", asrc, 0);
        drive('0, '0, 1'b1);
        tick();
        chk("single_drain", avalid, 0);

        fixed_payload();
`ifdef ARW_WR_PRIO_EN
        // AW0 and AR1 held: four writes then one read
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(2'b01, 2'b10, 1'b1);
            tick();
            chk("prio_atype", atype, (i % 5 == 4) ? 1'b0 : 1'b1);
            chk("prio_asrc", asrc, (i % 5 == 4) ? 1'b1 : 1'b0);
        end
`else
        // Round-robin, backpressure and drain vectors
        tbl[0]  = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2'b11, 2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{2'b11, 2'b11, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].awv, tbl[i].arv, tbl[i].rdy);
            tick();
            chk($sformatf("vec%0d_awready", i), s_aw, tbl[i].e_aw);
            chk($sformatf("vec%0d_arready", i), s_ar, tbl[i].e_ar);
            chk($sformatf("vec%0d_avalid", i), avalid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_asrc", i), asrc, tbl[i].e_src);
                chk($sformatf("vec%0d_atype", i), atype, tbl[i].e_type);
            end
        end
`endif

        // Reset while FULL: output drops without a clock edge, then restarts at AW0
        drive('1, '1, 1'b1);
        tick();
        drive('1, '1, 1'b0);
        tick();
        chk("midrst_full", avalid, 1);
        #2 arst = 1'b1;
        #1 chk("midrst_async_avalid", avalid, 0);
        model_reset();
        @(posedge clk);
        #1 arst = 1'b0;
        drive('1, '1, 1'b1);
        tick();
        chk("midrst_first_aw", s_aw, 2'b01);
        chk("midrst_first_ar", s_ar, 2'b00);
        chk("midrst_atype", atype, 1);
        chk("midrst_asrc", asrc, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            awid = AID_LEN*NUM_CH'($urandom); arid = AID_LEN*NUM_CH'($urandom);
            awaddr = {$urandom, $urandom}; araddr = {$urandom, $urandom};
            awlen = 16'($urandom); arlen = 16'($urandom);
            drive(NUM_CH'($urandom), NUM_CH'($urandom), ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
